// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC register, pipelined in-order imem requests, QDEPTH-entry instruction queue and F/D register.
// Ports: clk, rst (async active-low); imem_req/imem_addr out, imem_rvalid/imem_rdata in;
//        stalld/flushd (hazard unit), redirect/redirect_pc (execute);
//        instrd/pcd/pc_4d/validd (F/D register).
// Optional: define FETCH_PERF_EN to add saturating perf_fetched/perf_dropped counters.
module fetch_queue_unit #(
  parameter int XLEN = 32,
  parameter int QDEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stalld,
  input  logic            flushd,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     instrd,
  output logic [XLEN-1:0] pcd,
  output logic [XLEN-1:0] pc_4d,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
`endif
  output logic            validd
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] pc_q [QDEPTH];
  logic [31:0]     instr_q [QDEPTH];
  logic [AW-1:0]   head, fill_idx, alloc_idx;
  // occ counts allocated slots; outst counts allocated slots still awaiting data
  logic [CW-1:0]   occ, outst, filled;
  // responses still owed for requests abandoned by a redirect
  logic [15:0]     drop_cnt;
  logic            resp_fill, resp_drop, head_valid, pop;
  logic [31:0]     head_instr;
  always_comb begin
    filled     = occ - outst;
    fill_idx   = head + filled[AW-1:0];
    alloc_idx  = head + occ[AW-1:0];
    resp_drop  = imem_rvalid && drop_cnt != 0;
    resp_fill  = imem_rvalid && drop_cnt == 0;
    imem_req   = rst && !redirect && occ < CW'(QDEPTH);
    imem_addr  = pcf;
    // a response landing on an empty-data head is forwarded straight to F/D
    head_valid = filled != 0 || resp_fill;
    head_instr = filled != 0 ? instr_q[head] : imem_rdata;
    pop        = head_valid && !stalld && !flushd && !redirect;
  end
  always_ff @(posedge clk) begin
    if (imem_req) pc_q[alloc_idx] <= pcf;
    if (resp_fill) instr_q[fill_idx] <= imem_rdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf      <= RESET_PC;
      head     <= '0;
      occ      <= '0;
      outst    <= '0;
      drop_cnt <= '0;
      instrd   <= NOP_INSTR;
      pcd      <= '0;
      pc_4d    <= '0;
      validd   <= 1'b0;
    end else begin
      if (redirect) begin
        pcf      <= redirect_pc;
        occ      <= '0;
        outst    <= '0;
        drop_cnt <= drop_cnt + 16'(outst) - 16'(imem_rvalid);
      end else begin
        if (imem_req) pcf <= pcf + XLEN'(4);
        if (pop) head <= head + AW'(1);
        occ   <= occ + CW'(imem_req) - CW'(pop);
        outst <= outst + CW'(imem_req) - CW'(resp_fill);
        if (resp_drop) drop_cnt <= drop_cnt - 16'd1;
      end
      if (redirect || flushd || (!stalld && !pop)) begin
        instrd <= NOP_INSTR;
        pcd    <= '0;
        pc_4d  <= '0;
        validd <= 1'b0;
      end else if (pop) begin
        instrd <= head_instr;
        pcd    <= pc_q[head];
        pc_4d  <= pc_q[head] + XLEN'(4);
        validd <= 1'b1;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (resp_drop && perf_dropped != '1) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outst != 0 || drop_cnt != 0));
endmodule
